// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480 @ 60 Hz timing constants and the pixel
// coordinate type used by vga_sync and the downstream renderer stages.
//   VGA_H_* / VGA_V_*   : porch / sync / display widths and line/frame totals
//   VGA_*_SYNC_START/END: first and last coordinate of the active-low pulses
//   coord_t             : 10-bit unsigned pixel coordinate
package vga_timing_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_TICK_DIV  = 4;

  localparam int VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam int VGA_H_SYNC_START = VGA_H_DISPLAY + VGA_H_FRONT;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
  localparam int VGA_V_SYNC_START = VGA_V_DISPLAY + VGA_V_FRONT;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

endpackage

// File: rtl/vga_sync_if.sv
// vga_sync_if: timing bundle from vga_sync to the renderer / VGA connector.
//   master: driven by vga_sync; slave: consumed downstream.
//   p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start,
//   frame_cnt (only when VGA_SYNC_FRAME_CNT_EN is defined).
interface vga_sync_if;
  import vga_timing_pkg::*;

  logic   p_tick;
  coord_t pixel_x;
  coord_t pixel_y;
  logic   video_on;
  logic   hsync;
  logic   vsync;
  logic   frame_start;
`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] frame_cnt;

  modport master (output p_tick, pixel_x, pixel_y, video_on, hsync, vsync,
                         frame_start, frame_cnt);
  modport slave  (input  p_tick, pixel_x, pixel_y, video_on, hsync, vsync,
                         frame_start, frame_cnt);
`else
  modport master (output p_tick, pixel_x, pixel_y, video_on, hsync, vsync,
                         frame_start);
  modport slave  (input  p_tick, pixel_x, pixel_y, video_on, hsync, vsync,
                         frame_start);
`endif
endinterface

// File: rtl/vga_sync_mod_counter.sv
// mod_counter: enabled modulo counter, 0..MAX then back to 0.
//   clk, reset (sync, active-high), en: advance this cycle
//   count: current value; wrap: en && count==MAX (the edge that returns to 0)
module mod_counter #(
  parameter int MAX   = 3,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  assign wrap = en && (count == WIDTH'(MAX));

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of the order the always blocks are evaluated.
  always_ff @(posedge clk) begin
    if (reset)     count <= '0;
    else if (wrap) count <= '0;
    else if (en)   count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/vga_sync.sv
// vga_sync: 640x480 @ 60 Hz VGA timing from a 100 MHz clock.
//   clk   : system clock
//   reset : synchronous, active-high
//   vga   : vga_sync_if.master -- p_tick, pixel_x/pixel_y, video_on,
//           active-low hsync/vsync, frame_start, optional frame_cnt
// Build option: define VGA_SYNC_FRAME_CNT_EN to add the 8-bit frame counter.
// Timing parameters must give H_TOTAL, V_TOTAL <= 1024 (10-bit counters).
module vga_sync
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = VGA_H_DISPLAY,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_DISPLAY = VGA_V_DISPLAY,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK,
  parameter int TICK_DIV  = VGA_TICK_DIV
) (
  input  logic              clk,
  input  logic              reset,
  vga_sync_if.master        vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
  localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
  localparam coord_t HS_START = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HS_END   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_START = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t VS_END   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div, div_next;
  logic             div_wrap;
  coord_t           h_cnt, v_cnt, h_next, v_next;
  logic             h_wrap, v_wrap;
  logic             p_tick_q, hsync_q, vsync_q, video_on_q;

  mod_counter #(.MAX(TICK_DIV - 1), .WIDTH(DIV_W)) u_div (
    .clk(clk), .reset(reset), .en(1'b1), .count(div), .wrap(div_wrap)
  );

  mod_counter #(.MAX(H_TOTAL - 1), .WIDTH(COORD_W)) u_h (
    .clk(clk), .reset(reset), .en(p_tick_q), .count(h_cnt), .wrap(h_wrap)
  );

  // V steps only on the tick that ends a line.
  mod_counter #(.MAX(V_TOTAL - 1), .WIDTH(COORD_W)) u_v (
    .clk(clk), .reset(reset), .en(h_wrap), .count(v_cnt), .wrap(v_wrap)
  );

  // Values the counters will hold after this edge; the registered outputs
  // are decoded from these so they line up with pixel_x/pixel_y exactly.
  // NOTE: each always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    div_next = div + DIV_W'(1);
    if (div_wrap) div_next = '0;

    h_next = h_cnt;
    if (h_wrap)        h_next = '0;
    else if (p_tick_q) h_next = h_cnt + coord_t'(1);

    v_next = v_cnt;
    if (v_wrap)      v_next = '0;
    else if (h_wrap) v_next = v_cnt + coord_t'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_tick_q   <= 1'b0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      video_on_q <= 1'b1;
    end else begin
      p_tick_q   <= (div_next == DIV_LAST);
      hsync_q    <= !((h_next >= HS_START) && (h_next <= HS_END));
      vsync_q    <= !((v_next >= VS_START) && (v_next <= VS_END));
      video_on_q <= (h_next < H_VIS) && (v_next < V_VIS);
    end
  end

  assign vga.p_tick      = p_tick_q;
  assign vga.pixel_x     = h_cnt;
  assign vga.pixel_y     = v_cnt;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.video_on    = video_on_q;
  // v_wrap is exactly p_tick at (H_TOTAL-1, V_TOTAL-1).
  assign vga.frame_start = v_wrap;

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;
  logic       frame_cnt_wrap;

  mod_counter #(.MAX(255), .WIDTH(8)) u_frame (
    .clk(clk), .reset(reset), .en(v_wrap), .count(frame_cnt_q),
    .wrap(frame_cnt_wrap)
  );

  assign vga.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: two vga_sync instances -- default 640x480 timing (a) and a
// tiny 8x6-pixel, 3-clk-tick timing (b) so whole frames fit in a short run.
// A reference model derives every output from the clock count since reset.
module tb_vga_sync;

  // Small timing for instance b: H_TOTAL = 8, V_TOTAL = 6, frame = 144 clk.
  localparam int BH_D = 4, BH_F = 1, BH_S = 2, BH_B = 1;
  localparam int BV_D = 3, BV_F = 1, BV_S = 1, BV_B = 1;
  localparam int B_DIV   = 3;
  localparam int B_HT    = BH_D + BH_F + BH_S + BH_B;
  localparam int B_VT    = BV_D + BV_F + BV_S + BV_B;
  localparam int B_FRAME = B_DIV * B_HT * B_VT;

  logic clk     = 1'b0;
  logic reset_a = 1'b1;
  logic reset_b = 1'b1;
  int unsigned t_a = 0, t_b = 0;
  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  vga_sync_if vga_a();
  vga_sync_if vga_b();

  vga_sync dut_a (.clk(clk), .reset(reset_a), .vga(vga_a));

  vga_sync #(
    .H_DISPLAY(BH_D), .H_FRONT(BH_F), .H_SYNC(BH_S), .H_BACK(BH_B),
    .V_DISPLAY(BV_D), .V_FRONT(BV_F), .V_SYNC(BV_S), .V_BACK(BV_B),
    .TICK_DIV(B_DIV)
  ) dut_b (.clk(clk), .reset(reset_b), .vga(vga_b));

  always #5 clk = ~clk;

  typedef struct packed {
    logic       p_tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       frame_start;
    logic [7:0] frame_cnt;
  } obs_t;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // t = clk cycles since the last reset edge; pixel index = completed ticks.
  function automatic obs_t model(input int unsigned t, input int hd, hf, hs,
                                 hb, vd, vf, vs, vb, d);
    obs_t m;
    int ht, vt, idx, x, y;
    ht  = hd + hf + hs + hb;
    vt  = vd + vf + vs + vb;
    idx = int'((t / d) % (ht * vt));
    x   = idx % ht;
    y   = idx / ht;
    m.p_tick      = ((t % d) == d - 1);
    m.x           = 10'(x);
    m.y           = 10'(y);
    m.video_on    = (x < hd) && (y < vd);
    m.hsync       = !((x >= hd + hf) && (x < hd + hf + hs));
    m.vsync       = !((y >= vd + vf) && (y < vd + vf + vs));
    m.frame_start = m.p_tick && (idx == ht * vt - 1);
    m.frame_cnt   = 8'((t / (d * ht * vt)) % 256);
    return m;
  endfunction

  task automatic compare(input string pfx, input obs_t got, input obs_t exp);
    check({pfx, "_ptick"}, got.p_tick, exp.p_tick);
    check({pfx, "_x"}, got.x, exp.x);
    check({pfx, "_y"}, got.y, exp.y);
    check({pfx, "_von"}, got.video_on, exp.video_on);
    check({pfx, "_hs"}, got.hsync, exp.hsync);
    check({pfx, "_vs"}, got.vsync, exp.vsync);
    check({pfx, "_fs"}, got.frame_start, exp.frame_start);
`ifdef VGA_SYNC_FRAME_CNT_EN
    check({pfx, "_fcnt"}, got.frame_cnt, exp.frame_cnt);
`endif
  endtask

  always @(posedge clk) begin
    t_a <= reset_a ? 0 : t_a + 1;
    t_b <= reset_b ? 0 : t_b + 1;
  end

  always @(negedge clk) begin
    obs_t ga, gb;
    if (chk_on) begin
      ga = '0;
      gb = '0;
      ga.p_tick = vga_a.p_tick; ga.x = vga_a.pixel_x; ga.y = vga_a.pixel_y;
      ga.video_on = vga_a.video_on; ga.hsync = vga_a.hsync;
      ga.vsync = vga_a.vsync; ga.frame_start = vga_a.frame_start;
      gb.p_tick = vga_b.p_tick; gb.x = vga_b.pixel_x; gb.y = vga_b.pixel_y;
      gb.video_on = vga_b.video_on; gb.hsync = vga_b.hsync;
      gb.vsync = vga_b.vsync; gb.frame_start = vga_b.frame_start;
`ifdef VGA_SYNC_FRAME_CNT_EN
      ga.frame_cnt = vga_a.frame_cnt;
      gb.frame_cnt = vga_b.frame_cnt;
`endif
      compare("a", ga, model(t_a, 640, 16, 96, 48, 480, 10, 2, 33, 4));
      compare("b", gb, model(t_b, BH_D, BH_F, BH_S, BH_B,
                             BV_D, BV_F, BV_S, BV_B, B_DIV));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    chk_on = 1'b1;
    fork
      begin : branch_a
        int hs_cnt, hs_first, vid_fall, cyc, px, py;
        @(negedge clk);
        // Reset state.
        check("a_rst_x", vga_a.pixel_x, 0);
        check("a_rst_hs", vga_a.hsync, 1);
        check("a_rst_von", vga_a.video_on, 1);
        reset_a = 1'b0;
        for (int c = 0; c < 12; c++) begin
          check("a_rel_ptick", vga_a.p_tick, (c == 3) || (c == 7) || (c == 11));
          check("a_rel_x", vga_a.pixel_x, c / 4);
          check("a_rel_von", vga_a.video_on, 1);
          @(negedge clk);
        end
        // One full line.
        hs_cnt = 0; hs_first = -1; vid_fall = -1; cyc = 12;
        px = vga_a.pixel_x; py = vga_a.pixel_y;
        while (vga_a.pixel_y == 0 && cyc < 4000) begin
          if (!vga_a.hsync) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = int'(vga_a.pixel_x);
          end
          if (!vga_a.video_on && vid_fall < 0) vid_fall = int'(vga_a.pixel_x);
          px = int'(vga_a.pixel_x);
          py = int'(vga_a.pixel_y);
          @(negedge clk);
          cyc++;
        end
        check("a_line_period", cyc, 3200);
        check("a_wrap_prev_x", px, 799);
        check("a_wrap_prev_y", py, 0);
        check("a_wrap_x", vga_a.pixel_x, 0);
        check("a_wrap_y", vga_a.pixel_y, 1);
        check("a_hs_len", hs_cnt, 384);
        check("a_hs_start_x", hs_first, 656);
        check("a_von_fall_x", vid_fall, 640);
        // One-cycle reset mid-line.
        cyc = 0;
        while (vga_a.pixel_x != 300 && cyc < 4000) begin
          @(negedge clk);
          cyc++;
        end
        check("a_reach_x300", vga_a.pixel_x, 300);
        reset_a = 1'b1;
        @(negedge clk);
        reset_a = 1'b0;
        check("a_mid_rst_x", vga_a.pixel_x, 0);
        check("a_mid_rst_y", vga_a.pixel_y, 0);
        check("a_mid_rst_hs", vga_a.hsync, 1);
        check("a_mid_rst_vs", vga_a.vsync, 1);
        for (int c = 0; c < 8; c++) begin
          check("a_phase_ptick", vga_a.p_tick, (c == 3) || (c == 7));
          @(negedge clk);
        end
        // Random reset pulses; the per-cycle model checks every output.
        repeat (4) begin
          repeat ($urandom_range(20, 1500)) @(negedge clk);
          reset_a = 1'b1;
          repeat ($urandom_range(1, 3)) @(negedge clk);
          reset_a = 1'b0;
        end
        repeat (3300) @(negedge clk);
      end
      begin : branch_b
        int nfs, last_fs, cyc, vs_low, vid_bad;
        bit after_fs;
        @(negedge clk);
        reset_b = 1'b0;
        repeat (4) begin
          repeat ($urandom_range(30, 400)) @(negedge clk);
          reset_b = 1'b1;
          repeat ($urandom_range(1, 3)) @(negedge clk);
          reset_b = 1'b0;
        end
        // Clean run of 257 frames from reset.
        reset_b = 1'b1;
        @(negedge clk);
        reset_b = 1'b0;
        nfs = 0; last_fs = -1; cyc = 0; vs_low = 0; vid_bad = 0; after_fs = 0;
        while (nfs < 257 && cyc < 257 * B_FRAME + 100) begin
          if (after_fs) begin
            check("b_after_fs_x", vga_b.pixel_x, 0);
            check("b_after_fs_y", vga_b.pixel_y, 0);
            after_fs = 0;
          end
          if (!vga_b.vsync) vs_low++;
          if (vga_b.video_on && vga_b.pixel_y >= BV_D) vid_bad++;
          if (vga_b.frame_start) begin
            nfs++;
            check("b_fs_x", vga_b.pixel_x, B_HT - 1);
            check("b_fs_y", vga_b.pixel_y, B_VT - 1);
            if (last_fs >= 0) check("b_fs_period", cyc - last_fs, B_FRAME);
            else check("b_fs_first", cyc, B_FRAME - 1);
            last_fs = cyc;
            after_fs = 1;
          end
          @(negedge clk);
          cyc++;
        end
        check("b_fs_count", nfs, 257);
        check("b_end_x", vga_b.pixel_x, 0);
        check("b_end_y", vga_b.pixel_y, 0);
        check("b_vs_low", vs_low, 257 * BV_S * B_HT * B_DIV);
        check("b_von_blank", vid_bad, 0);
`ifdef VGA_SYNC_FRAME_CNT_EN
        check("b_fcnt_257", vga_b.frame_cnt, 1);
`endif
      end
    join
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
